// File: rtl/ifu_fetch_decode.sv
// Instruction fetch and jump/branch decode feeding the IFU control inputs.
// Synchronous-read instruction memory with a load port and a HOLD/RUN/LOAD fetch FSM.
module ifu_fetch_decode #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [29:0]          pc_word,
    input  logic                 alu_zero,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [31:0]          load_data,
    output logic [31:0]          instr,
    output logic [25:0]          targetInstr,
    output logic [15:0]          imm16,
    output logic                 branch,
    output logic                 jump,
    output logic                 is_link,
    output logic [15:0]          fetch_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;
    logic        fetchEn;

    logic [31:0] mem [DEPTH];

    logic [5:0] opcode;
    logic       isJ;
    logic       isJal;
    logic       isBeq;
    logic       isBne;

    // Upper word-address bits alias onto the memory index.
    logic unusedPcBits;
    assign unusedPcBits = ^pc_word[29:ADDR_BITS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HOLD;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = HOLD;
        if (load_en) begin
            nextState = LOAD;
        end else begin
            case (state)
                LOAD:    nextState = HOLD;
                HOLD:    nextState = RUN;
                RUN:     nextState = RUN;
                default: nextState = HOLD;
            endcase
        end
    end

    always_comb begin
        fetchEn = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr <= 32'h0;
        end else if (fetchEn) begin
            instr <= mem[pc_word[ADDR_BITS-1:0]];
        end else begin
            instr <= 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= 16'h0;
        end else if (fetchEn) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

    assign opcode      = instr[31:26];
    assign targetInstr = instr[25:0];
    assign imm16       = instr[15:0];

    assign isJ   = (opcode == 6'b000010);
    assign isJal = (opcode == 6'b000011);
    assign isBeq = (opcode == 6'b000100);
    assign isBne = (opcode == 6'b000101);

    // jump is active-low toward the IFU.
    always_comb begin
        jump    = 1'b1;
        branch  = 1'b0;
        is_link = 1'b0;
        unique case (1'b1)
            isJ: begin
                jump = 1'b0;
            end
            isJal: begin
                jump    = 1'b0;
                is_link = 1'b1;
            end
            isBeq: begin
                branch = alu_zero;
            end
            isBne: begin
                branch = !alu_zero;
            end
            default: begin
                jump = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_fetch_decode.sv
// Randomized scoreboard bench for ifu_fetch_decode.
// A spec-level model predicts every output sample; a monitor pops and compares.
module tb_ifu_fetch_decode;

    localparam int AB    = 10;
    localparam int DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [29:0]   pc_word = '0;
    logic          alu_zero = 1'b0;
    logic          load_en = 1'b0;
    logic [AB-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic [31:0]   instr;
    logic [25:0]   targetInstr;
    logic [15:0]   imm16;
    logic          branch;
    logic          jump;
    logic          is_link;
    logic [15:0]   fetch_count;

    ifu_fetch_decode #(.ADDR_BITS(AB)) dut (
        .clk(clk),
        .reset(reset),
        .pc_word(pc_word),
        .alu_zero(alu_zero),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .instr(instr),
        .targetInstr(targetInstr),
        .imm16(imm16),
        .branch(branch),
        .jump(jump),
        .is_link(is_link),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] cnt;
        logic        az;
    } exp_t;

    exp_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Reference state: memory image, last instr, counter, and the number of
    // consecutive edges since the last reset/load that let fetching begin.
    logic [31:0] mMem [DEPTH];
    logic [31:0] mInstr = '0;
    logic [15:0] mCnt = '0;
    int          quiet = 0;

    task automatic modelEdge();
        if (!reset) begin
            mInstr = 32'h0;
            mCnt   = 16'h0;
            quiet  = 1;
        end else begin
            // Fetching needs two quiet edges behind it (reset counts as one).
            if (quiet >= 2) begin
                mInstr = mMem[pc_word % DEPTH];
                mCnt   = mCnt + 16'd1;
            end else begin
                mInstr = 32'h0;
            end
            if (load_en) begin
                mMem[load_addr] = load_data;
                quiet = 0;
            end else if (quiet < 2) begin
                quiet = quiet + 1;
            end
        end
    endtask

    task automatic pushExp();
        exp_t e;
        e.instr = mInstr;
        e.cnt   = mCnt;
        e.az    = alu_zero;
        expQ.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic le,
                         input logic [AB-1:0] la, input logic [31:0] ld,
                         input logic [29:0] pc, input logic az,
                         input logic az2);
        @(posedge clk);
        modelEdge();
        #1;
        reset     = r;
        load_en   = le;
        load_addr = la;
        load_data = ld;
        pc_word   = pc;
        alu_zero  = az;
        pushExp();
        @(negedge clk);
        #1;
        alu_zero = az2;
        pushExp();
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareNow();
        exp_t e;
        logic [5:0] op;
        logic eJump;
        logic eLink;
        logic eBranch;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
        end else begin
            e       = expQ.pop_front();
            op      = e.instr[31:26];
            eJump   = !(op == 6'd2 || op == 6'd3);
            eLink   = (op == 6'd3);
            eBranch = (op == 6'd4 && e.az) || (op == 6'd5 && !e.az);
            check("instr", instr, e.instr);
            check("targetInstr", {6'h0, targetInstr}, {6'h0, e.instr[25:0]});
            check("imm16", {16'h0, imm16}, {16'h0, e.instr[15:0]});
            check("jump", {31'h0, jump}, {31'h0, eJump});
            check("is_link", {31'h0, is_link}, {31'h0, eLink});
            check("branch", {31'h0, branch}, {31'h0, eBranch});
            check("fetch_count", {16'h0, fetch_count}, {16'h0, e.cnt});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compareNow();
            #3;
            compareNow();
        end
    end

    function automatic logic [31:0] fillWord(input int i);
        case (i)
            0:       return 32'h08000003;
            2:       return 32'h0C000010;
            4:       return 32'h1000FFFE;
            5:       return 32'h14000003;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b1, AB'(i), fillWord(i), '0, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        // Release: one HOLD edge, then RUN fetching the J at word 0.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0, '0, 30'd0, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b0, '0, '0, 30'd2, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 30'd4, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 30'd5, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 30'd5, 1'b1, 1'b0);
        // Reload word 0 mid-run, then read it back through an aliased address.
        cycle(1'b1, 1'b1, '0, 32'h10000001, 30'h400, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, '0, '0, 30'h400, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic le;
            r  = ($urandom_range(0, 63) != 0);
            le = ($urandom_range(0, 9) == 0);
            cycle(r, le, AB'($urandom), $urandom, 30'($urandom),
                  1'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, '0, '0, 30'($urandom), 1'b0, 1'b1);
        end
        #5;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d left expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
